// File: rtl/plic_gateway_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : plic_gateway_pkg
//  Description : Shared types and constants for the PLIC interrupt gateway.
//                Holds the per-source gateway FSM state encoding and the
//                legal ranges of the gateway parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package plic_gateway_pkg;

  // Per-source gateway state. The encoding is fixed because ip_o is decoded
  // directly from it.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_CLAIMED = 2'd2
  } gw_state_e;

  // Legal parameter ranges.
  localparam int unsigned N_SOURCE_MIN    = 1;
  localparam int unsigned N_SOURCE_MAX    = 255;
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

endpackage : plic_gateway_pkg
`default_nettype wire

// File: rtl/plic_gateway_sync.sv
`default_nettype none
// ============================================================================
//  Module      : plic_gateway_sync
//  Description : Single-bit multi-flop synchronizer for one raw interrupt
//                line. All flops clear to 0 on reset.
//  Ports       : clk_i  - clock
//                rst_i  - asynchronous active-high reset
//                d_i    - raw asynchronous input
//                q_o    - synchronized output (last flop of the chain)
//  Revision    : 1.0 - initial release
// ============================================================================
module plic_gateway_sync
  import plic_gateway_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] stage;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage <= '0;
    end else begin
      stage <= {stage[STAGES-2:0], d_i};
    end
  end

  assign q_o = stage[STAGES-1];

endmodule : plic_gateway_sync
`default_nettype wire

// File: rtl/plic_gateway.sv
`default_nettype none
// ============================================================================
//  Module      : plic_gateway
//  Description : PLIC interrupt gateway. Each source is synchronized,
//                converted into a set request (rising edge or level-high
//                according to le_i) and tracked by an IDLE/PENDING/CLAIMED
//                state machine. ip_o reports the sources currently pending.
//  Ports       : clk_i       - clock, all state updates on rising edge
//                rst_i       - asynchronous active-high reset
//                src_i       - raw asynchronous interrupt lines
//                le_i        - trigger mode per source (1 edge, 0 level)
//                claim_i     - one-cycle claim pulse per source
//                complete_i  - one-cycle completion pulse per source
//                ip_o        - interrupt-pending vector (from state regs)
//  Revision    : 1.0 - initial release
// ============================================================================
module plic_gateway
  import plic_gateway_pkg::*;
#(
  parameter int N_SOURCE    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_SOURCE-1:0] src_i,
  input  logic [N_SOURCE-1:0] le_i,
  input  logic [N_SOURCE-1:0] claim_i,
  input  logic [N_SOURCE-1:0] complete_i,
  output logic [N_SOURCE-1:0] ip_o
);

  logic [N_SOURCE-1:0] sync_q;
  logic [N_SOURCE-1:0] sync_d;
  logic [N_SOURCE-1:0] rise;
  logic [N_SOURCE-1:0] set_req;
  logic [N_SOURCE-1:0] edge_latch;

  // One extra flop behind the synchronizer gives the previous sample for
  // edge detection. It clears on reset, so a line held high through reset
  // is seen as a fresh rising edge once synchronized.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_d <= '0;
    end else begin
      sync_d <= sync_q;
    end
  end

  assign rise    = sync_q & ~sync_d;
  assign set_req = (le_i & rise) | (~le_i & sync_q);

  for (genvar i = 0; i < N_SOURCE; i++) begin : g_src

    gw_state_e state;
    gw_state_e state_nxt;
    logic      latch_q;
    logic      latch_nxt;

    plic_gateway_sync #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (src_i[i]),
      .q_o   (sync_q[i])
    );

    // Only the current state decides which handshake is honoured, so a
    // simultaneous claim and complete resolves without ambiguity.
    always_comb begin
      state_nxt = state;
      case (state)
        ST_IDLE: begin
          if (set_req[i] || latch_q) begin
            state_nxt = ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (claim_i[i]) begin
            state_nxt = ST_CLAIMED;
          end
        end
        ST_CLAIMED: begin
          if (complete_i[i]) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    // An edge arriving while the interrupt is being serviced must not be
    // lost; it is remembered here and replayed once the source returns to
    // IDLE. Edges while PENDING are already covered by the pending request.
    always_comb begin
      latch_nxt = latch_q;
      if (!le_i[i]) begin
        latch_nxt = 1'b0;
      end else if ((state == ST_IDLE) && (state_nxt == ST_PENDING)) begin
        latch_nxt = 1'b0;
      end else if ((state == ST_CLAIMED) && rise[i]) begin
        latch_nxt = 1'b1;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state   <= ST_IDLE;
        latch_q <= 1'b0;
      end else begin
        state   <= state_nxt;
        latch_q <= latch_nxt;
      end
    end

    assign edge_latch[i] = latch_q;
    assign ip_o[i]       = (state == ST_PENDING);

  end : g_src

endmodule : plic_gateway
`default_nettype wire

// File: tb/tb_plic_gateway.sv
`default_nettype none
// ============================================================================
//  Module      : tb_plic_gateway
//  Description : Self-checking bench for plic_gateway. A 4-source instance
//                exercises directed scenarios; a 32-source instance is run
//                against a cycle-accurate reference model with random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_plic_gateway;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [3:0]  src4, le4, clm4, cmp4;
  logic [3:0]  ip4;
  logic [31:0] src32, le32, clm32, cmp32;
  logic [31:0] ip32;

  int tests = 0;
  int fails = 0;

  // reference model state for the 32-source instance (2 sync stages)
  logic [31:0] m_s1, m_s2, m_d, m_lat;
  logic [1:0]  m_st [32];

  int   rises;
  logic prev0;

  always #5 clk = ~clk;

  plic_gateway #(.N_SOURCE(4), .SYNC_STAGES(2)) dut4 (
    .clk_i      (clk),
    .rst_i      (rst),
    .src_i      (src4),
    .le_i       (le4),
    .claim_i    (clm4),
    .complete_i (cmp4),
    .ip_o       (ip4)
  );

  plic_gateway #(.N_SOURCE(32), .SYNC_STAGES(2)) dut32 (
    .clk_i      (clk),
    .rst_i      (rst),
    .src_i      (src32),
    .le_i       (le32),
    .claim_i    (clm32),
    .complete_i (cmp32),
    .ip_o       (ip32)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_cnt;
    tick();
    if (ip4[0] && !prev0) rises++;
    prev0 = ip4[0];
  endtask

  // Advance the reference model by one clock edge using the inputs that the
  // edge is about to sample.
  task automatic model_step;
    logic [31:0] r;
    logic        s;
    r = m_s2 & ~m_d;
    for (int i = 0; i < 32; i++) begin
      s = le32[i] ? r[i] : m_s2[i];
      case (m_st[i])
        2'd0: if (s || m_lat[i]) begin m_st[i] = 2'd1; m_lat[i] = 1'b0; end
        2'd1: if (clm32[i]) m_st[i] = 2'd2;
        2'd2: begin
          if (le32[i] && r[i]) m_lat[i] = 1'b1;
          if (cmp32[i]) m_st[i] = 2'd0;
        end
        default: m_st[i] = 2'd0;
      endcase
      if (!le32[i]) m_lat[i] = 1'b0;
    end
    m_d  = m_s2;
    m_s2 = m_s1;
    m_s1 = src32;
  endtask

  function automatic logic [31:0] model_mask(input logic [1:0] code);
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = (m_st[i] == code);
    return v;
  endfunction

  initial begin
    src4 = '0; le4 = '0; clm4 = '0; cmp4 = '0;
    src32 = '0; le32 = '0; clm32 = '0; cmp32 = '0;
    m_s1 = '0; m_s2 = '0; m_d = '0; m_lat = '0;
    for (int i = 0; i < 32; i++) m_st[i] = 2'd0;
    rises = 0;
    prev0 = 1'b0;

    // ---------------- reset state
    #3;
    check("reset_ip4", {28'd0, ip4}, 32'h0);
    check("reset_ip32", ip32, 32'h0);
    #10 rst = 1'b0;
    tick();

    // ---------------- level mode, source 1
    src4[1] = 1'b1;
    tick();                                   // edge k
    check("lvl_k", {28'd0, ip4}, 32'h0);
    tick();                                   // edge k+1
    check("lvl_k1", {28'd0, ip4}, 32'h0);
    tick();                                   // edge k+2
    check("lvl_pend", {28'd0, ip4}, 32'h2);
    repeat (3) tick();
    clm4[1] = 1'b1; tick(); clm4[1] = 1'b0;
    check("lvl_claim", {28'd0, ip4}, 32'h0);
    repeat (2) tick();
    check("lvl_claim_hold", {28'd0, ip4}, 32'h0);
    cmp4[1] = 1'b1; tick(); cmp4[1] = 1'b0;
    check("lvl_cmp_idle", {28'd0, ip4}, 32'h0);
    tick();
    check("lvl_repend", {28'd0, ip4}, 32'h2);
    src4[1] = 1'b0;
    clm4[1] = 1'b1; tick(); clm4[1] = 1'b0;
    repeat (3) tick();
    cmp4[1] = 1'b1; tick(); cmp4[1] = 1'b0;
    tick();
    check("lvl_cleared", {28'd0, ip4}, 32'h0);

    // ---------------- edge coalescing, source 0
    le4[0] = 1'b1;
    repeat (3) begin
      src4[0] = 1'b1; tick_cnt();
      src4[0] = 1'b0; tick_cnt();
    end
    repeat (6) tick_cnt();
    check("edge_coalesce_cnt", rises, 32'd1);
    check("edge_pend", {28'd0, ip4}, 32'h1);
    clm4[0] = 1'b1; tick(); clm4[0] = 1'b0;
    check("edge_claim", {28'd0, ip4}, 32'h0);
    cmp4[0] = 1'b1; tick(); cmp4[0] = 1'b0;
    repeat (4) tick();
    check("edge_no_repend", {28'd0, ip4}, 32'h0);

    // ---------------- edge during CLAIMED, source 2
    le4[2] = 1'b1;
    src4[2] = 1'b1; tick(); src4[2] = 1'b0;
    repeat (3) tick();
    check("clm_edge_pend", {28'd0, ip4}, 32'h4);
    clm4[2] = 1'b1; tick(); clm4[2] = 1'b0;
    check("clm_edge_claim", {28'd0, ip4}, 32'h0);
    src4[2] = 1'b1; tick(); src4[2] = 1'b0;
    repeat (4) tick();
    check("clm_edge_hidden", {28'd0, ip4}, 32'h0);
    cmp4[2] = 1'b1; tick(); cmp4[2] = 1'b0;
    check("clm_edge_idle", {28'd0, ip4}, 32'h0);
    tick();
    check("clm_edge_repend", {28'd0, ip4}, 32'h4);

    // ---------------- illegal handshakes (source 2 left pending)
    clm4 = 4'b1011; tick(); clm4 = 4'b0000;
    check("idle_claim_ign", {28'd0, ip4}, 32'h4);
    cmp4 = 4'b0100; tick(); cmp4 = 4'b0000;
    check("pend_cmp_ign", {28'd0, ip4}, 32'h4);
    src4[3] = 1'b1;
    repeat (3) tick();
    check("lvl3_pend", {28'd0, ip4}, 32'hC);
    clm4[3] = 1'b1; cmp4[3] = 1'b1; tick(); clm4[3] = 1'b0; cmp4[3] = 1'b0;
    check("clm_cmp_together", {28'd0, ip4}, 32'h4);
    tick();
    check("clm_cmp_stays_claimed", {28'd0, ip4}, 32'h4);

    // ---------------- reset mid-operation
    // source 0: claimed with a latched edge; 2 pending; 3 claimed, held high
    src4[0] = 1'b1; tick(); src4[0] = 1'b0;
    repeat (3) tick();
    check("pre_rst_src0_pend", {28'd0, ip4}, 32'h5);
    clm4[0] = 1'b1; tick(); clm4[0] = 1'b0;
    src4[0] = 1'b1; tick(); src4[0] = 1'b0;
    repeat (3) tick();
    check("pre_rst", {28'd0, ip4}, 32'h4);
    #2 rst = 1'b1;
    #1;
    check("rst_async", {28'd0, ip4}, 32'h0);
    #1 rst = 1'b0;
    tick();
    check("post_rst_e1", {28'd0, ip4}, 32'h0);
    tick();
    check("post_rst_e2", {28'd0, ip4}, 32'h0);
    tick();
    check("post_rst_e3", {28'd0, ip4}, 32'h8);
    repeat (3) tick();
    check("post_rst_no_latch", {28'd0, ip4}, 32'h8);

    // ---------------- randomized 32-source run against the model
    for (int c = 0; c < 300; c++) begin
      if (c == 0 || c == 150) le32 = $urandom;
      src32 = $urandom;
      clm32 = $urandom & $urandom;
      cmp32 = $urandom & $urandom;
      model_step();
      tick();
      check("rand_ip", ip32, model_mask(2'd1));
      check("rand_no_ip_claimed", ip32 & model_mask(2'd2), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_plic_gateway
`default_nettype wire
